imem_loader: RTL and testbench

- Boot-time writer for the processor's instruction memory; the fetch path is the reader of that memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive word-aligned addresses, then checks a checksum.
- Holds the processor in reset until a load completes successfully.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/byte_word_packer.sv | 41 ++++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  // Position of the next byte within the 32-bit word being assembled.
  typedef logic [1:0] byte_idx_t;

  // Word count carried in the frame header.
  typedef logic [15:0] word_cnt_t;

  localparam int CSUM_WIDTH = 8;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles accepted bytes into little-endian 32-bit words.
// word/word_valid are combinational on the 4th byte so the parent can
// register the write on the same edge that accepts that byte.
module byte_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  byte_idx_t   idx;
  logic [23:0] shift;

  // The 4th byte bypasses the shifter and lands directly in the top lane.
  assign word       = {data, shift};
  assign word_valid = accept && (idx == 2'd3);

  // Byte index and lower three lanes of the word under construction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples values from before the edge.
    if (reset || clear) begin
      idx   <= '0;
      shift <= '0;
    end else if (accept) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    shift[7:0]   <= data;
        2'd1:    shift[15:8]  <= data;
        2'd2:    shift[23:16] <= data;
        default: ; // top lane comes straight from data
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a framed byte stream,
// writes little-endian words to consecutive addresses, verifies an 8-bit
// checksum and keeps the processor in reset until a load is verified.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        hold_cpu,
  output logic        done,
  output logic        error
);

  state_t                 state;
  word_cnt_t              n_words;
  word_cnt_t              word_cnt;
  logic [7:0]             len_lo;
  logic [CSUM_WIDTH-1:0]  csum_acc;

  logic                   accept;
  logic                   can_start;
  logic                   pack_accept;
  word_cnt_t              len_word;
  logic                   too_long;
  logic [CSUM_WIDTH-1:0]  csum_final;
  logic [31:0]            word;
  logic                   word_valid;

  assign accept      = in_valid && in_ready;
  assign can_start   = start && (state == IDLE || state == DONE || state == ERROR);
  assign pack_accept = accept && (state == DATA);
  assign len_word    = {in_data, len_lo};
  // A count above capacity would run the address past the end of memory.
  assign too_long    = ({16'd0, len_word} > (32'd1 << ADDR_WIDTH));
  assign csum_final  = csum_acc + in_data;

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (can_start),
    .accept     (pack_accept),
    .data       (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Load sequencer: frame parsing, write port, checksum and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      hold_cpu <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      n_words  <= '0;
      word_cnt <= '0;
      len_lo   <= '0;
      csum_acc <= '0;
    end else begin
      // The write register is separate from the shifter so bytes of the
      // next word can stream in while this word is being written.
      wr_en <= word_valid;
      if (word_valid) wr_data <= word;
      if (wr_en)      wr_addr <= wr_addr + 32'd4;

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= LEN_LO;
            in_ready <= 1'b1;
            hold_cpu <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            wr_addr  <= BASE_ADDR;
            word_cnt <= '0;
            csum_acc <= '0;
          end
        end

        LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (accept) begin
            n_words <= len_word;
            if (too_long) begin
              state    <= ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else if (len_word == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) csum_acc <= csum_acc + in_data;
          if (word_valid) begin
            word_cnt <= word_cnt + 16'd1;
            if (word_cnt == n_words - 16'd1) state <= CSUM;
          end
        end

        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (csum_final == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              hold_cpu <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A frame-level model derives the
// expected write sequence (address, word, cycle) and the load outcome
// directly from the frame bytes; a compare process checks every cycle.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          CAP  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        hold_cpu;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_WIDTH(10), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .hold_cpu (hold_cpu),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  frame[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: every write must be the next one the model predicted,
  // at exactly the predicted cycle; status invariants hold on every cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_t e;
      n_writes++;
      last_addr = wr_addr;
      last_data = wr_data;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        check("wr_cycle", 32'(pcyc), 32'(e.cyc));
      end
    end
    check("done_error_excl", 32'(done & error), 32'd0);
    check("hold_vs_done", 32'(hold_cpu), 32'(!done));
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wr_en"},    32'(wr_en),    32'd0);
    check({tag, "_wr_addr"},  wr_addr,       BASE);
    check({tag, "_wr_data"},  wr_data,       32'd0);
    check({tag, "_hold_cpu"}, 32'(hold_cpu), 32'd1);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_error"},    32'(error),    32'd0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Header + n data bytes (simple pattern) + checksum; good selects a
  // checksum that makes the byte sum zero mod 256.
  task automatic make_frame(input int n, input bit good);
    logic [7:0] sum;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    sum = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      frame.push_back(8'(i * 7 + 3));
      sum = sum + 8'(i * 7 + 3);
    end
    frame.push_back(good ? 8'(-sum) : 8'(8'd1 - sum));
  endtask

  // Sends the first nsend bytes of frame; optional random gaps on in_valid
  // and an optional start pulse while presenting byte start_at.
  task automatic run_frame(input int nsend, input bit gaps, input int start_at);
    int         n;
    int         j;
    bit         complete;
    bit         exp_done;
    logic [7:0] sum;
    n = {24'd0, frame[1], frame[0]};
    sum = 8'd0;
    for (int i = 2; i < frame.size(); i++) sum = sum + frame[i];
    complete = (n > CAP) ? (nsend >= 2) : (nsend == 2 + 4 * n + 1);
    exp_done = (n <= CAP) && (sum == 8'd0);

    for (int i = 0; i < nsend; i++) begin
      int tries = 0;
      bit acc   = 1'b0;
      while (!acc) begin
        @(negedge clk);
        start    = (i == start_at) && (tries == 0);
        in_data  = frame[i];
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        acc      = in_valid && in_ready;
        tries++;
        if (!acc && tries > 200) begin
          check("accept_timeout", 32'd0, 32'd1);
          in_valid = 1'b0;
          start    = 1'b0;
          return;
        end
      end
      if (i >= 2 && n <= CAP) begin
        j = i - 2;
        if (j < 4 * n && (j % 4) == 3)
          exp_q.push_back('{BASE + 32'(4 * (j / 4)),
                            {frame[i], frame[i-1], frame[i-2], frame[i-3]},
                            pcyc + 1});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    if (complete) begin
      check("outcome_done",  32'(done),     32'(exp_done));
      check("outcome_error", 32'(error),    32'(!exp_done));
      check("outcome_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_basic(input logic [7:0] csum);
    frame.delete();
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
              8'h93, 8'h05, 8'h10, 8'h00, csum};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset    = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // IDLE: valid bytes without start must not be consumed.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      check("idle_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // Basic load. Data bytes sum to 0xC0, so 0x40 is the passing checksum.
    load_basic(8'h40);
    w0 = n_writes;
    do_start();
    run_frame(11, 1'b0, -1);
    check("basic_nwrites",  32'(n_writes - w0), 32'd2);
    check("basic_last_addr", last_addr, 32'h0000_0004);
    check("basic_last_data", last_data, 32'h0010_0593);
    check("basic_done",     32'(done),     32'd1);
    check("basic_hold",     32'(hold_cpu), 32'd0);

    // Bad checksum: writes still happen, then ERROR.
    load_basic(8'h00);
    w0 = n_writes;
    do_start();
    run_frame(11, 1'b0, -1);
    check("badcs_nwrites", 32'(n_writes - w0), 32'd2);
    check("badcs_error",   32'(error),    32'd1);
    check("badcs_done",    32'(done),     32'd0);
    check("badcs_hold",    32'(hold_cpu), 32'd1);
    check("badcs_ready",   32'(in_ready), 32'd0);

    // Backpressure gaps plus a start pulse in the middle of DATA.
    load_basic(8'h40);
    w0 = n_writes;
    do_start();
    run_frame(11, 1'b1, 5);
    check("gaps_nwrites", 32'(n_writes - w0), 32'd2);
    check("gaps_done",    32'(done), 32'd1);

    // N = 0: no writes, straight to checksum.
    frame.delete();
    frame = '{8'h00, 8'h00, 8'h00};
    w0 = n_writes;
    do_start();
    run_frame(3, 1'b0, -1);
    check("n0_nwrites", 32'(n_writes - w0), 32'd0);
    check("n0_done",    32'(done), 32'd1);

    // N = 1025: rejected right after the count.
    frame.delete();
    frame = '{8'h01, 8'h04};
    w0 = n_writes;
    do_start();
    run_frame(2, 1'b0, -1);
    check("n1025_error",   32'(error), 32'd1);
    check("n1025_nwrites", 32'(n_writes - w0), 32'd0);

    // N = 1024: full capacity, last write at 0xFFC.
    make_frame(1024, 1'b1);
    w0 = n_writes;
    do_start();
    run_frame(frame.size(), 1'b0, -1);
    check("n1024_nwrites",   32'(n_writes - w0), 32'd1024);
    check("n1024_last_addr", last_addr, 32'h0000_0FFC);
    check("n1024_done",      32'(done), 32'd1);

    // Reset after 2 words + 2 bytes of a 4-word frame.
    make_frame(4, 1'b1);
    w0 = n_writes;
    do_start();
    run_frame(12, 1'b0, -1);
    check("midrst_nwrites", 32'(n_writes - w0), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_more", 32'(n_writes - w0), 32'd2);
    load_basic(8'h40);
    do_start();
    run_frame(11, 1'b0, -1);
    check("restart_last_addr", last_addr, 32'h0000_0004);
    check("restart_done",      32'(done), 32'd1);

    // Reload from DONE with a 1-word frame.
    frame.delete();
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
    frame[6] = 8'(-(8'h78 + 8'h56 + 8'h34 + 8'h12));
    do_start();
    check("reload_done_drop", 32'(done),     32'd0);
    check("reload_hold",      32'(hold_cpu), 32'd1);
    run_frame(7, 1'b0, -1);
    check("reload_addr", last_addr, BASE);
    check("reload_data", last_data, 32'h1234_5678);
    check("reload_done", 32'(done), 32'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
